// File: rtl/imul_rr_arbiter.sv
// Round-robin front end that shares one iterative multiplier among several
// requesters. Exactly one operation is in flight; the result is steered back
// only to the requester that issued it.
module imul_rr_arbiter #(
    parameter int p_num_reqs   = 4,
    parameter int p_msg_nbits  = 64,
    parameter int p_resp_nbits = 32,
    localparam int p_idx_nbits = (p_num_reqs > 1) ? $clog2(p_num_reqs) : 1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [p_num_reqs-1:0]             req_val,
    output logic [p_num_reqs-1:0]             req_rdy,
    input  logic [p_num_reqs*p_msg_nbits-1:0] req_msg,
    output logic [p_num_reqs-1:0]             resp_val,
    input  logic [p_num_reqs-1:0]             resp_rdy,
    output logic [p_resp_nbits-1:0]           resp_msg,
    output logic                              mul_istream_val,
    input  logic                              mul_istream_rdy,
    output logic [p_msg_nbits-1:0]            mul_istream_msg,
    input  logic                              mul_ostream_val,
    output logic                              mul_ostream_rdy,
    input  logic [p_resp_nbits-1:0]           mul_ostream_msg,
    output logic [p_idx_nbits-1:0]            owner,
    output logic [31:0]                       busy_cycles
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t                 state_reg, state_next;
    logic [p_idx_nbits-1:0] prio_reg, prio_next;
    logic [p_idx_nbits-1:0] owner_reg, owner_next;
    logic [31:0]            busy_cycles_reg, busy_cycles_next;
    logic [p_idx_nbits-1:0] grant;
    logic                   any_req;
    logic [p_msg_nbits-1:0] msg_arr [p_num_reqs];

    // Unpack the flat request bus into one message per requester.
    generate
        for (genvar gi = 0; gi < p_num_reqs; gi++) begin : g_msg
            assign msg_arr[gi] = req_msg[gi*p_msg_nbits +: p_msg_nbits];
        end
    endgenerate

    assign any_req     = |req_val;
    assign resp_msg    = mul_ostream_msg;
    assign owner       = owner_reg;
    assign busy_cycles = busy_cycles_reg;

    // Grant: first valid requester scanning cyclically from prio. Scanning the
    // offsets from farthest to nearest lets the nearest valid one win last.
    always_comb begin
        int idx;
        grant = '0;
        idx   = 0;
        for (int k = p_num_reqs - 1; k >= 0; k--) begin
            idx = int'(prio_reg) + k;
            if (idx >= p_num_reqs) begin
                idx = idx - p_num_reqs;
            end
            if (req_val[idx]) begin
                grant = p_idx_nbits'(idx);
            end
        end
    end

    // Next-state, handshake steering and busy-cycle accounting.
    always_comb begin
        state_next       = state_reg;
        prio_next        = prio_reg;
        owner_next       = owner_reg;
        busy_cycles_next = busy_cycles_reg;
        req_rdy          = '0;
        resp_val         = '0;
        mul_istream_val  = 1'b0;
        mul_istream_msg  = '0;
        mul_ostream_rdy  = 1'b0;
        case (state_reg)
            IDLE: begin
                mul_istream_val = any_req;
                // Compare rather than index so a 1-requester build stays clean.
                for (int i = 0; i < p_num_reqs; i++) begin
                    if (int'(grant) == i) begin
                        req_rdy[i] = mul_istream_rdy;
                        if (any_req) begin
                            mul_istream_msg = msg_arr[i];
                        end
                    end
                end
                if (any_req && mul_istream_rdy) begin
                    owner_next = grant;
                    state_next = BUSY;
                    if (int'(grant) == p_num_reqs - 1) begin
                        prio_next = '0;
                    end else begin
                        prio_next = grant + p_idx_nbits'(1);
                    end
                end
            end
            BUSY: begin
                busy_cycles_next = busy_cycles_reg + 32'd1;
                for (int i = 0; i < p_num_reqs; i++) begin
                    if (int'(owner_reg) == i) begin
                        resp_val[i]     = mul_ostream_val;
                        mul_ostream_rdy = resp_rdy[i];
                    end
                end
                // The owner may stall indefinitely; everyone else waits.
                if (mul_ostream_val && mul_ostream_rdy) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State registers; reset drops any in-flight result.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= IDLE;
            prio_reg        <= '0;
            owner_reg       <= '0;
            busy_cycles_reg <= '0;
        end else begin
            state_reg       <= state_next;
            prio_reg        <= prio_next;
            owner_reg       <= owner_next;
            busy_cycles_reg <= busy_cycles_next;
        end
    end

endmodule
